mm2s_stream_checker: RTL and testbench
======================================

MM2S_STREAM_CHECKER -- requirements
Module: mm2s_stream_checker

Interface
REQ-001 SHALL have parameter BEATS, default 1024: number of 64-bit beats expected per transfer (1..65535).
REQ-002 SHALL have parameter RD_DIV, default 8: tready is offered one cycle in every RD_DIV cycles (1..256; 1 = always ready).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that arms a check run.
REQ-006 SHALL have port seed, input, 64: expected value of beat 0, sampled on start.
REQ-007 SHALL have ports s_axis_tdata (in, 64), s_axis_tkeep (in, 8), s_axis_tlast (in, 1), s_axis_tvalid (in, 1) and s_axis_tready (out, 1): the MM2S read-back stream sink.
REQ-008 SHALL have port busy, output, 1: high while a run is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at the end of a run.
REQ-010 SHALL have port pass, output, 1: high when the last run had err_count==0; held until the next start.
REQ-011 SHALL have ports err_count (out, 16), beat_count (out, 16), first_err_idx (out, 16), first_err_data (out, 64) and tlast_err (out, 1).

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 SHALL take these transitions: IDLE->RUN on start; RUN->DONE on the accepted beat with index BEATS-1; DONE->IDLE after exactly one cycle.
REQ-014 SHALL assert done only in the DONE state and hold busy high in RUN and DONE.
REQ-015 SHALL, on start, load expected=seed, clear beat_count, err_count, first_err_idx, first_err_data and tlast_err, clear pass, and load the divider with RD_DIV-1.
REQ-016 SHALL ignore start while in RUN or DONE.
REQ-017 SHALL run the divider in RUN only, decrementing modulo RD_DIV; s_axis_tready is registered and is 1 in the cycle after the divider reaches 0.
REQ-018 SHALL hold s_axis_tready at 0 in IDLE and DONE.
REQ-019 SHALL count a beat as accepted only when s_axis_tvalid && s_axis_tready; tdata, tkeep and tlast are sampled only on accepted beats.
REQ-020 SHALL flag an accepted beat as an error if tdata!=expected or tkeep!=8'hFF.
REQ-021 SHALL increment expected by 1 modulo 2^64 on every accepted beat, whether or not that beat is in error (FFFF_FFFF_FFFF_FFFF wraps to 0).
REQ-022 SHALL increment beat_count on each accepted beat.
REQ-023 SHALL increment err_count per erroneous beat and saturate it at 16'hFFFF.
REQ-024 SHALL, on the first erroneous beat of a run only, capture first_err_idx=beat_count (pre-increment) and first_err_data=tdata.
REQ-025 SHALL, on DONE, set pass=(err_count==0), including any error from the final beat.
REQ-026 SHALL hold all status outputs stable from DONE until the next start.

Reset
REQ-027 SHALL, on reset, set state=IDLE, s_axis_tready=0, busy=0, done=0, pass=0, err_count=0, beat_count=0, first_err_idx=0, first_err_data=0, tlast_err=0 and expected=0.
REQ-028 SHALL let reset override start and abort a run in progress mid-transfer, with no done pulse issued.

Configuration
REQ-029 SHALL use the macro MM2S_CHECK_TLAST_EN to compile tlast checking in or out.
REQ-030 SHALL, when MM2S_CHECK_TLAST_EN is defined, treat an accepted beat as erroneous (per REQ-023) and set tlast_err sticky if tlast=1 on any index other than BEATS-1, or tlast=0 on index BEATS-1.
REQ-031 SHALL, when MM2S_CHECK_TLAST_EN is undefined, ignore s_axis_tlast and tie tlast_err to 0.

Verification
REQ-032 SHALL cover: BEATS=16, RD_DIV=8, seed=0x100, tvalid always 1, incrementing data -> tready duty 1/8; done after 16 beats; pass=1, err_count=0, beat_count=16.
REQ-033 SHALL cover: beat 5 data corrupted to 0xDEAD -> err_count=1, first_err_idx=5, first_err_data=0xDEAD, pass=0; beat 6 (0x106) not flagged.
REQ-034 SHALL cover: seed=0xFFFF_FFFF_FFFF_FFFE, BEATS=4 -> expected sequence FE, FF, 0, 1 (wrap); pass=1.
REQ-035 SHALL cover: tvalid toggled randomly, RD_DIV=1 -> only handshaked beats counted; pass=1; start pulsed during RUN ignored.
REQ-036 SHALL cover: with MM2S_CHECK_TLAST_EN, tlast=1 on beat 3 of 16 -> tlast_err=1, err_count=1; without the macro -> pass=1.
REQ-037 SHALL cover: reset asserted at beat 7 -> next cycle all outputs equal their reset values and no done pulse occurs.

Source files
------------

// File: rtl/mm2s_stream_checker_if.sv
// Beat channel between an MM2S read-back source (master) and the stream checker (slave).
interface mm2s_stream_checker_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/mm2s_stream_checker.sv
// Checks an MM2S read-back stream against an incrementing 64-bit pattern and reports error status.
// Define MM2S_CHECK_TLAST_EN to also check tlast placement (last beat only) and report tlast_err.
module mm2s_stream_checker #(
    parameter int unsigned BEATS  = 1024,
    parameter int unsigned RD_DIV = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [63:0]                 seed,
    mm2s_stream_checker_if.slave        s_axis,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [15:0]                 err_count,
    output logic [15:0]                 beat_count,
    output logic [15:0]                 first_err_idx,
    output logic [63:0]                 first_err_data,
    output logic                        tlast_err
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DIV_W  = 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RD_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;
    logic [CNT_W-1:0]    beat_count_q, beat_count_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [CNT_W-1:0]    first_err_idx_q, first_err_idx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tready_q, tready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
`ifdef MM2S_CHECK_TLAST_EN
    logic                tlast_err_q, tlast_err_d;
`endif

    logic accept;
    logic last_beat;
    logic tlast_bad;
    logic beat_bad;

    // Next-state and status update
    always_comb begin
        state_d          = state_q;
        expected_d       = expected_q;
        first_err_data_d = first_err_data_q;
        beat_count_d     = beat_count_q;
        err_count_d      = err_count_q;
        first_err_idx_d  = first_err_idx_q;
        div_d            = div_q;
        tready_d         = 1'b0;
        pass_d           = pass_q;
`ifdef MM2S_CHECK_TLAST_EN
        tlast_err_d      = tlast_err_q;
`endif

        accept    = (state_q == RUN) && s_axis.tvalid && tready_q;
        last_beat = (beat_count_q == LAST_IDX);
        tlast_bad = 1'b0;
`ifdef MM2S_CHECK_TLAST_EN
        tlast_bad = (s_axis.tlast != last_beat);
`endif
        beat_bad  = (s_axis.tdata != expected_q) || (s_axis.tkeep != {KEEP_W{1'b1}}) || tlast_bad;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = RUN;
                    expected_d       = seed;
                    beat_count_d     = '0;
                    err_count_d      = '0;
                    first_err_idx_d  = '0;
                    first_err_data_d = '0;
                    pass_d           = 1'b0;
                    div_d            = DIV_LOAD;
`ifdef MM2S_CHECK_TLAST_EN
                    tlast_err_d      = 1'b0;
`endif
                end
            end
            RUN: begin
                // Ready is offered the cycle after the divider hits zero
                div_d    = (div_q == '0) ? DIV_LOAD : div_q - DIV_W'(1);
                tready_d = (div_q == '0);
                if (accept) begin
                    expected_d   = expected_q + DATA_W'(1);
                    beat_count_d = beat_count_q + CNT_W'(1);
                    if (beat_bad) begin
                        if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
                        if (err_count_q == '0) begin
                            first_err_idx_d  = beat_count_q;
                            first_err_data_d = s_axis.tdata;
                        end
                    end
`ifdef MM2S_CHECK_TLAST_EN
                    tlast_err_d = tlast_err_q | tlast_bad;
`endif
                    if (last_beat) begin
                        state_d  = DONE;
                        tready_d = 1'b0;
                        pass_d   = (err_count_q == '0) && !beat_bad;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            expected_q       <= '0;
            first_err_data_q <= '0;
            beat_count_q     <= '0;
            err_count_q      <= '0;
            first_err_idx_q  <= '0;
            div_q            <= '0;
            tready_q         <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
`ifdef MM2S_CHECK_TLAST_EN
            tlast_err_q      <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            expected_q       <= expected_d;
            first_err_data_q <= first_err_data_d;
            beat_count_q     <= beat_count_d;
            err_count_q      <= err_count_d;
            first_err_idx_q  <= first_err_idx_d;
            div_q            <= div_d;
            tready_q         <= tready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
`ifdef MM2S_CHECK_TLAST_EN
            tlast_err_q      <= tlast_err_d;
`endif
        end
    end

    assign s_axis.tready  = tready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign beat_count     = beat_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;

`ifdef MM2S_CHECK_TLAST_EN
    assign tlast_err = tlast_err_q;
`else
    // tlast is deliberately ignored in this build
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
    assign tlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mm2s_stream_checker.sv
// Scoreboard bench for mm2s_stream_checker: two instances (RD_DIV=8 and RD_DIV=1), driven one at a time.
module tb_mm2s_stream_checker;
    localparam int unsigned BEATS = 16;
    localparam int unsigned DIV_A = 8;
    localparam int unsigned DIV_B = 1;
    localparam int          BEAT_BUDGET = 200;

    typedef struct packed {
        logic [15:0] err;
        logic [15:0] beats;
        logic [15:0] idx;
        logic [63:0] data;
        logic        tl;
        logic        pass;
    } res_t;

    logic        clk = 1'b0;
    logic        reset, start, sel;
    logic [63:0] seed;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast, tvalid;

    logic        busy_a, done_a, pass_a, tle_a, busy_b, done_b, pass_b, tle_b;
    logic [15:0] err_a, bc_a, idx_a, err_b, bc_b, idx_b;
    logic [63:0] fed_a, fed_b;

    logic        busy_m, done_m, pass_m, tle_m, tready_m;
    logic [15:0] err_m, bc_m, idx_m;
    logic [63:0] fed_m;

    logic [63:0] s_data [BEATS];
    logic [7:0]  s_keep [BEATS];
    logic        s_last [BEATS];

    res_t exp_q[$];
    res_t last_r;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    int   rdy_cyc = 0;

    always #5 clk = ~clk;

    mm2s_stream_checker_if ifa();
    mm2s_stream_checker_if ifb();

    assign ifa.tdata  = tdata;
    assign ifa.tkeep  = tkeep;
    assign ifa.tlast  = tlast;
    assign ifa.tvalid = tvalid & ~sel;
    assign ifb.tdata  = tdata;
    assign ifb.tkeep  = tkeep;
    assign ifb.tlast  = tlast;
    assign ifb.tvalid = tvalid & sel;

    mm2s_stream_checker #(.BEATS(BEATS), .RD_DIV(DIV_A)) dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .seed(seed), .s_axis(ifa),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .beat_count(bc_a),
        .first_err_idx(idx_a), .first_err_data(fed_a), .tlast_err(tle_a));

    mm2s_stream_checker #(.BEATS(BEATS), .RD_DIV(DIV_B)) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .seed(seed), .s_axis(ifb),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .beat_count(bc_b),
        .first_err_idx(idx_b), .first_err_data(fed_b), .tlast_err(tle_b));

    assign busy_m   = sel ? busy_b : busy_a;
    assign done_m   = sel ? done_b : done_a;
    assign pass_m   = sel ? pass_b : pass_a;
    assign tle_m    = sel ? tle_b  : tle_a;
    assign err_m    = sel ? err_b  : err_a;
    assign bc_m     = sel ? bc_b   : bc_a;
    assign idx_m    = sel ? idx_b  : idx_a;
    assign fed_m    = sel ? fed_b  : fed_a;
    assign tready_m = sel ? ifb.tready : ifa.tready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: beat i should carry seed+i with full keep, tlast only on the final beat
    function automatic res_t model(input logic [63:0] s);
        res_t        r;
        logic [63:0] want;
        bit          lbad;
        r = '0;
        for (int i = 0; i < BEATS; i++) begin
            want = s + 64'(i);
            lbad = 1'b0;
`ifdef MM2S_CHECK_TLAST_EN
            lbad = (s_last[i] != (i == BEATS - 1));
`endif
            if (s_data[i] != want || s_keep[i] != 8'hFF || lbad) begin
                if (r.err == 16'd0) begin
                    r.idx  = 16'(i);
                    r.data = s_data[i];
                end
                if (r.err != 16'hFFFF) r.err = r.err + 16'd1;
            end
            if (lbad) r.tl = 1'b1;
        end
        r.beats = 16'(BEATS);
        r.pass  = (r.err == 16'd0);
        return r;
    endfunction

    task automatic fill_clean(input logic [63:0] s);
        for (int i = 0; i < BEATS; i++) begin
            s_data[i] = s + 64'(i);
            s_keep[i] = 8'hFF;
            s_last[i] = (i == BEATS - 1);
        end
    endtask

    // Monitor: scoreboard compare on every done pulse, plus activity counters per run
    always @(negedge clk) begin
        if (start) begin
            busy_cyc = 0;
            rdy_cyc  = 0;
        end else begin
            if (busy_m)   busy_cyc++;
            if (tready_m) rdy_cyc++;
        end
        if (done_m) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse with empty scoreboard (t=%0t)", $time);
            end else begin
                last_r = exp_q.pop_front();
                chk("err_count",      64'(err_m), 64'(last_r.err));
                chk("beat_count",     64'(bc_m),  64'(last_r.beats));
                chk("first_err_idx",  64'(idx_m), 64'(last_r.idx));
                chk("first_err_data", fed_m,      last_r.data);
                chk("tlast_err",      64'(tle_m), 64'(last_r.tl));
                chk("pass",           64'(pass_m), 64'(last_r.pass));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},   64'(busy_m),   64'd0);
        chk({tag, "_done"},   64'(done_m),   64'd0);
        chk({tag, "_pass"},   64'(pass_m),   64'd0);
        chk({tag, "_err"},    64'(err_m),    64'd0);
        chk({tag, "_beats"},  64'(bc_m),     64'd0);
        chk({tag, "_idx"},    64'(idx_m),    64'd0);
        chk({tag, "_fdata"},  fed_m,         64'd0);
        chk({tag, "_tlerr"},  64'(tle_m),    64'd0);
        chk({tag, "_tready"}, 64'(tready_m), 64'd0);
    endtask

    // Drive one run; abort_at >= 0 asserts reset instead of sending that beat
    task automatic run_stream(input logic [63:0] s, input bit use_b, input bit rand_valid,
                              input int abort_at);
        int budget;
        bit acc;
        int d0;
        sel = use_b;
        if (abort_at < 0) exp_q.push_back(model(s));
        d0 = done_cnt;
        seed = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            if (i == abort_at) begin
                tvalid = 1'b0;
                chk("pre_abort_beats", 64'(bc_m), 64'(abort_at));
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk_reset_state("abort");
                return;
            end
            acc = 1'b0;
            budget = 0;
            while (!acc) begin
                tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                tdata  = tvalid ? s_data[i] : {$urandom, $urandom};
                tkeep  = tvalid ? s_keep[i] : 8'($urandom);
                tlast  = tvalid ? s_last[i] : 1'($urandom_range(0, 1));
                if (use_b && i == 8 && budget == 0) begin
                    start = 1'b1;
                    seed  = {$urandom, $urandom};
                end
                acc = tvalid && tready_m;
                @(posedge clk); #1;
                start = 1'b0;
                budget++;
                if (!acc && budget > BEAT_BUDGET) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", i, BEAT_BUDGET);
                    tvalid = 1'b0;
                    void'(exp_q.pop_back());
                    return;
                end
            end
        end
        tvalid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done_cnt != d0) break;
            @(posedge clk); #1;
        end
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
        if (done_cnt == d0 && exp_q.size() > 0) void'(exp_q.pop_back());
        if (!rand_valid) begin
            chk("busy_cycles",  64'(busy_cyc), 64'((use_b ? DIV_B : DIV_A) * BEATS + 2));
            chk("tready_cycles", 64'(rdy_cyc), 64'(BEATS));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(done_m), 64'd0);
        chk("pass_held",      64'(pass_m), 64'(last_r.pass));
        chk("err_held",       64'(err_m),  64'(last_r.err));
    endtask

    initial begin
        logic [63:0] rs;
        int          d0;
        reset = 1'b1; start = 1'b0; sel = 1'b0; seed = '0;
        tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst_a");
        sel = 1'b1; #1;
        chk_reset_state("rst_b");
        reset = 1'b0;
        sel = 1'b0;
        @(posedge clk); #1;

        // Clean incrementing run, tready duty 1/8
        fill_clean(64'h100);
        run_stream(64'h100, 1'b0, 1'b0, -1);

        // Beat 5 corrupted; beat 6 still matches since expected keeps counting
        fill_clean(64'h100);
        s_data[5] = 64'hDEAD;
        run_stream(64'h100, 1'b0, 1'b0, -1);

        // 64-bit wrap of the expected counter
        fill_clean(64'hFFFF_FFFF_FFFF_FFFE);
        run_stream(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, -1);

        // Always-ready instance, random tvalid, stray start mid-run
        rs = {$urandom, $urandom};
        fill_clean(rs);
        run_stream(rs, 1'b1, 1'b1, -1);

        // Early tlast on beat 3
        fill_clean(64'h200);
        s_last[3] = 1'b1;
        run_stream(64'h200, 1'b0, 1'b0, -1);

        // Random seeds with random data/keep corruption on both instances
        for (int r = 0; r < 4; r++) begin
            rs = {$urandom, $urandom};
            fill_clean(rs);
            for (int i = 0; i < BEATS; i++) begin
                if ($urandom_range(0, 5) == 0) s_data[i] = s_data[i] ^ (64'd1 << $urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) s_keep[i] = 8'($urandom_range(0, 254));
            end
            run_stream(rs, r[0], 1'b1, -1);
        end

        // Reset at beat 7 aborts the run with no done pulse
        fill_clean(64'h300);
        s_data[2] = 64'hBAD;
        d0 = done_cnt;
        run_stream(64'h300, 1'b0, 1'b0, 7);
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        chk_reset_state("post_abort");

        // Reset overrides a simultaneous start
        sel = 1'b0;
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        chk("rst_over_start_busy", 64'(busy_m), 64'd0);
        @(posedge clk); #1;
        chk("rst_over_start_busy2", 64'(busy_m), 64'd0);

        // Recovery run after reset
        fill_clean(64'h400);
        run_stream(64'h400, 1'b0, 1'b0, -1);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
